// File: rtl/friscv_rv32i_control.sv
// ============================================================================
// Module   : friscv_rv32i_control
// Brief    : RV32I sequencer: PC, fetch, control-flow execute, ALU dispatch.
//            Optional FRISCV_ILLEGAL_HALT_EN: halt on illegal instruction.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ALU_INSTBUS_W
`define ALU_INSTBUS_W 69
`endif

module friscv_rv32i_control #(
  parameter int ADDRW     = 16,
  parameter int BOOT_ADDR = 0,
  parameter int XLEN      = 32
)(
  input  logic                      aclk,
  input  logic                      srst,
  output logic                      inst_en,
  output logic [ADDRW-1:0]          inst_addr,
  input  logic [XLEN-1:0]           inst_rdata,
  input  logic                      inst_ready,
  output logic                      alu_en,
  input  logic                      alu_ready,
  input  logic                      alu_empty,
  output logic [`ALU_INSTBUS_W-1:0] alu_instbus,
  output logic [4:0]                ctrl_rs1_addr,
  input  logic [XLEN-1:0]           ctrl_rs1_val,
  output logic [4:0]                ctrl_rs2_addr,
  input  logic [XLEN-1:0]           ctrl_rs2_val,
  output logic                      ctrl_rd_wr,
  output logic [4:0]                ctrl_rd_addr,
  output logic [XLEN-1:0]           ctrl_rd_val
);

  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_opimm  = 7'b0010011;
  localparam logic [6:0] c_op_op     = 7'b0110011;
  localparam logic [6:0] c_op_lui    = 7'b0110111;
  localparam logic [6:0] c_op_misc   = 7'b0001111;
  localparam logic [6:0] c_op_system = 7'b1110011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_auipc  = 7'b0010111;
  localparam logic [6:0] c_op_nop    = 7'b0000000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   w_pc_next;
  logic [31:0]       r_instr;
  logic              w_instr_load;

  logic [6:0]        w_opcode;
  logic [2:0]        w_funct3;
  logic              w_is_branch;
  logic              w_branch_ok;
  logic              w_alu_cls;
  logic              w_ctrl_cls;
  logic              w_illegal;
  logic              w_taken;
  logic              inst_error;

  logic signed [31:0] w_imm_i32;
  logic signed [31:0] w_imm_b32;
  logic signed [31:0] w_imm_j32;
  logic [XLEN-1:0]   w_imm_i;
  logic [XLEN-1:0]   w_imm_b;
  logic [XLEN-1:0]   w_imm_j;
  logic [XLEN-1:0]   w_imm_u;
  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_jalr_sum;
  logic [XLEN-1:0]   w_ctrl_pc;

  assign w_opcode      = r_instr[6:0];
  assign w_funct3      = r_instr[14:12];
  assign ctrl_rs1_addr = r_instr[19:15];
  assign ctrl_rs2_addr = r_instr[24:20];
  assign ctrl_rd_addr  = r_instr[11:7];
  assign inst_addr     = r_pc[ADDRW-1:0];

  // The instruction register only changes in FETCH, so the bus is stable
  // for as long as the ALU back-pressures.
  assign alu_instbus = {r_instr[31:12], r_instr[31:20], r_instr[19:15],
                        r_instr[11:7], r_instr[24:20], r_instr[19:15],
                        r_instr[31:25], r_instr[14:12], r_instr[6:0]};

  assign w_is_branch = (w_opcode == c_op_branch);
  assign w_branch_ok = w_is_branch && (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
  assign w_alu_cls   = (w_opcode == c_op_load)  || (w_opcode == c_op_store) ||
                       (w_opcode == c_op_opimm) || (w_opcode == c_op_op)    ||
                       (w_opcode == c_op_lui)   || (w_opcode == c_op_misc)  ||
                       (w_opcode == c_op_system);
  assign w_ctrl_cls  = (w_opcode == c_op_jal) || (w_opcode == c_op_jalr) ||
                       (w_opcode == c_op_auipc) || w_branch_ok;
  assign w_illegal   = !(w_alu_cls || w_ctrl_cls || (w_opcode == c_op_nop));
  assign inst_error  = (r_state == S_EXEC) && w_illegal;

  assign w_imm_i32 = {{20{r_instr[31]}}, r_instr[31:20]};
  assign w_imm_b32 = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                      r_instr[30:25], r_instr[11:8], 1'b0};
  assign w_imm_j32 = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                      r_instr[20], r_instr[30:21], 1'b0};
  assign w_imm_i   = XLEN'(w_imm_i32);
  assign w_imm_b   = XLEN'(w_imm_b32);
  assign w_imm_j   = XLEN'(w_imm_j32);
  assign w_imm_u   = XLEN'($signed({r_instr[31:12], 12'b0}));

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_jalr_sum = ctrl_rs1_val + w_imm_i;

  always_comb begin
    w_taken = 1'b0;
    case (w_funct3)
      3'b000:  w_taken = (ctrl_rs1_val == ctrl_rs2_val);
      3'b001:  w_taken = (ctrl_rs1_val != ctrl_rs2_val);
      3'b100:  w_taken = ($signed(ctrl_rs1_val) <  $signed(ctrl_rs2_val));
      3'b101:  w_taken = ($signed(ctrl_rs1_val) >= $signed(ctrl_rs2_val));
      3'b110:  w_taken = (ctrl_rs1_val <  ctrl_rs2_val);
      3'b111:  w_taken = (ctrl_rs1_val >= ctrl_rs2_val);
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_ctrl_pc   = w_pc_plus4;
    ctrl_rd_val = w_pc_plus4;
    case (w_opcode)
      c_op_auipc: ctrl_rd_val = r_pc + w_imm_u;
      c_op_jal:   w_ctrl_pc   = r_pc + w_imm_j;
      c_op_jalr:  w_ctrl_pc   = {w_jalr_sum[XLEN-1:1], 1'b0};
      c_op_branch: if (w_taken) w_ctrl_pc = r_pc + w_imm_b;
      default: ;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_load = 1'b0;
    inst_en      = 1'b0;
    alu_en       = 1'b0;
    ctrl_rd_wr   = 1'b0;
    case (r_state)
      S_FETCH: begin
        inst_en = 1'b1;
        if (inst_ready) begin
          w_instr_load = 1'b1;
          w_state_next = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_alu_cls) begin
          alu_en = 1'b1;
          if (alu_ready) begin
            w_pc_next    = w_pc_plus4;
            w_state_next = S_FETCH;
          end
        end else if (w_ctrl_cls) begin
          // Wait for the ALU to drain so rs1/rs2 reflect retired results.
          if (alu_empty) begin
            ctrl_rd_wr   = !w_is_branch;
            w_pc_next    = w_ctrl_pc;
            w_state_next = S_FETCH;
          end
        end else if (!w_illegal) begin
          w_pc_next    = w_pc_plus4;
          w_state_next = S_FETCH;
        end else begin
`ifdef FRISCV_ILLEGAL_HALT_EN
          w_state_next = S_HALT;
`else
          w_pc_next    = w_pc_plus4;
          w_state_next = S_FETCH;
`endif
        end
      end
      S_HALT:  ;
      default: w_state_next = S_FETCH;
    endcase
    if (srst) begin
      inst_en    = 1'b0;
      alu_en     = 1'b0;
      ctrl_rd_wr = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge aclk) begin
    if (srst) begin
      r_pc    <= XLEN'(BOOT_ADDR);
      r_instr <= 32'h0;
    end else begin
      r_pc <= w_pc_next;
      if (w_instr_load) r_instr <= inst_rdata[31:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_friscv_rv32i_control.sv
// ============================================================================
// Module   : tb_friscv_rv32i_control
// Brief    : Directed self-checking bench for friscv_rv32i_control.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef ALU_INSTBUS_W
`define ALU_INSTBUS_W 69
`endif

module tb_friscv_rv32i_control;

  logic                      aclk = 1'b0;
  logic                      srst;
  logic                      inst_en;
  logic [15:0]               inst_addr;
  logic [31:0]               inst_rdata;
  logic                      inst_ready;
  logic                      alu_en;
  logic                      alu_ready;
  logic                      alu_empty;
  logic [`ALU_INSTBUS_W-1:0] alu_instbus;
  logic [4:0]                ctrl_rs1_addr;
  logic [31:0]               ctrl_rs1_val;
  logic [4:0]                ctrl_rs2_addr;
  logic [31:0]               ctrl_rs2_val;
  logic                      ctrl_rd_wr;
  logic [4:0]                ctrl_rd_addr;
  logic [31:0]               ctrl_rd_val;

  int checks = 0;
  int errors = 0;

  always #5 aclk = ~aclk;

  friscv_rv32i_control #(.ADDRW(16), .BOOT_ADDR(0), .XLEN(32)) dut (
    .aclk(aclk), .srst(srst),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_ready(inst_ready),
    .alu_en(alu_en), .alu_ready(alu_ready), .alu_empty(alu_empty),
    .alu_instbus(alu_instbus),
    .ctrl_rs1_addr(ctrl_rs1_addr), .ctrl_rs1_val(ctrl_rs1_val),
    .ctrl_rs2_addr(ctrl_rs2_addr), .ctrl_rs2_val(ctrl_rs2_val),
    .ctrl_rd_wr(ctrl_rd_wr), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_val(ctrl_rd_val)
  );

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    srst = 1'b1; inst_ready = 1'b0; alu_ready = 1'b0; alu_empty = 1'b1;
    inst_rdata = 32'h0; ctrl_rs1_val = 32'h0; ctrl_rs2_val = 32'h0;
    step(); step();
    srst = 1'b0;
    #1;
  endtask

  // Bounded wait for a fetch request, then hand over one instruction.
  task automatic fetch(input logic [31:0] ins);
    int n = 0;
    #1;
    while (inst_en !== 1'b1 && n < 20) begin step(); n++; end
    checks++;
    if (inst_en !== 1'b1) begin
      errors++;
      $display("FAIL fetch_timeout: inst_en=%b required 1", inst_en);
    end
    inst_rdata = ins; inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; inst_ready = 1'b0; alu_ready = 1'b0; alu_empty = 1'b1;
    inst_rdata = 32'h0; ctrl_rs1_val = 32'h0; ctrl_rs2_val = 32'h0;
    step(); step();
    checks++;
    if ({inst_en, alu_en, ctrl_rd_wr} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs: en/alu/wr=%b required 000", {inst_en, alu_en, ctrl_rd_wr});
    end
    srst = 1'b0;
    #1;
    checks++;
    if (inst_en !== 1'b1 || inst_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset_fetch: inst_en=%b addr=%h required 1/0000", inst_en, inst_addr);
    end
    fetch(32'h0000_0000);
    checks++;
    if (dut.inst_error !== 1'b0 || alu_en !== 1'b0 || ctrl_rd_wr !== 1'b0) begin
      errors++;
      $display("FAIL nop_exec: err/alu/wr=%b%b%b required 000", dut.inst_error, alu_en, ctrl_rd_wr);
    end
    step();
    checks++;
    if (inst_en !== 1'b1 || inst_addr !== 16'h0004) begin
      errors++;
      $display("FAIL nop_pc: inst_en=%b addr=%h required 1/0004", inst_en, inst_addr);
    end
  endtask

  task automatic test_auipc();
    apply_reset();
    fetch(32'h0000_1197);
    checks++;
    if (ctrl_rd_wr !== 1'b1 || ctrl_rd_addr !== 5'd3 || ctrl_rd_val !== 32'h0000_1000) begin
      errors++;
      $display("FAIL auipc_rd: wr=%b addr=%0d val=%h required 1/3/00001000", ctrl_rd_wr, ctrl_rd_addr, ctrl_rd_val);
    end
    step();
    checks++;
    if (inst_addr !== 16'h0004 || ctrl_rd_wr !== 1'b0) begin
      errors++;
      $display("FAIL auipc_pc: addr=%h wr=%b required 0004/0", inst_addr, ctrl_rd_wr);
    end
  endtask

  task automatic test_jal_jalr();
    apply_reset();
    fetch(32'h0000_0000);
    step();
    fetch(32'h0010_02EF);          // jal x5, +2048 at pc=4
    checks++;
    if (ctrl_rd_wr !== 1'b1 || ctrl_rd_addr !== 5'd5 || ctrl_rd_val !== 32'h8) begin
      errors++;
      $display("FAIL jal_rd: wr=%b addr=%0d val=%h required 1/5/00000008", ctrl_rd_wr, ctrl_rd_addr, ctrl_rd_val);
    end
    step();
    checks++;
    if (inst_addr !== 16'h0804) begin
      errors++;
      $display("FAIL jal_pc: addr=%h required 0804", inst_addr);
    end
    ctrl_rs1_val = 32'h0000_0103;
    fetch(32'h0001_00E7);          // jalr x1, 0(x2)
    checks++;
    if (ctrl_rs1_addr !== 5'd2 || ctrl_rd_addr !== 5'd1 || ctrl_rd_val !== 32'h808) begin
      errors++;
      $display("FAIL jalr_rd: rs1=%0d rd=%0d val=%h required 2/1/00000808", ctrl_rs1_addr, ctrl_rd_addr, ctrl_rd_val);
    end
    step();
    checks++;
    if (inst_addr !== 16'h0102) begin
      errors++;
      $display("FAIL jalr_pc: addr=%h required 0102", inst_addr);
    end
    ctrl_rs1_val = 32'h0000_0100;
    fetch(32'hFFC1_00E7);          // jalr x1, -4(x2)
    step();
    checks++;
    if (inst_addr !== 16'h00FC) begin
      errors++;
      $display("FAIL jalr_neg_pc: addr=%h required 00FC", inst_addr);
    end
  endtask

  task automatic test_branch();
    logic [31:0] ins [7]  = '{32'h0020_8863, 32'h0020_8863, 32'h0020_C863, 32'h0020_E863,
                              32'h0020_F863, 32'h0020_9863, 32'h0020_D863};
    logic [31:0] a   [7]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h00FF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] b   [7]  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h00FF_FFFF, 32'h00FF_FFFF,
                              32'h00FF_FFFF, 32'h0000_0000, 32'h00FF_FFFF};
    logic [15:0] exp [7]  = '{16'h0010, 16'h0004, 16'h0010, 16'h0004,
                              16'h0004, 16'h0010, 16'h0004};
    for (int i = 0; i < 7; i++) begin
      apply_reset();
      ctrl_rs1_val = a[i];
      ctrl_rs2_val = b[i];
      fetch(ins[i]);
      checks++;
      if (ctrl_rd_wr !== 1'b0) begin
        errors++;
        $display("FAIL branch%0d_nowrite: wr=%b required 0", i, ctrl_rd_wr);
      end
      step();
      checks++;
      if (inst_addr !== exp[i]) begin
        errors++;
        $display("FAIL branch%0d_pc: addr=%h required %h", i, inst_addr, exp[i]);
      end
    end
  endtask

  task automatic test_alu_stall();
    // addi x3, x1, -1 : op=13 f3=0 f7=7F rs1=1 rs2=1F rd=3 zimm=1 imm12=FFF imm20=FFF08
    logic [`ALU_INSTBUS_W-1:0] exp_bus;
    exp_bus = {20'hFFF08, 12'hFFF, 5'd1, 5'd3, 5'h1F, 5'd1, 7'h7F, 3'd0, 7'h13};
    apply_reset();
    fetch(32'hFFF0_8193);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alu_en !== 1'b1 || alu_instbus !== exp_bus || inst_en !== 1'b0 || inst_addr !== 16'h0) begin
        errors++;
        $display("FAIL alu_hold%0d: alu_en=%b bus=%h inst_en=%b addr=%h required 1/%h/0/0000",
                 i, alu_en, alu_instbus, inst_en, inst_addr, exp_bus);
      end
      step();
    end
    alu_ready = 1'b1;
    step();
    alu_ready = 1'b0;
    #1;
    checks++;
    if (alu_en !== 1'b0 || inst_en !== 1'b1 || inst_addr !== 16'h0004) begin
      errors++;
      $display("FAIL alu_accept: alu_en=%b inst_en=%b addr=%h required 0/1/0004", alu_en, inst_en, inst_addr);
    end
  endtask

  task automatic test_hazard();
    apply_reset();
    alu_empty = 1'b0;
    fetch(32'h0010_02EF);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctrl_rd_wr !== 1'b0 || inst_en !== 1'b0) begin
        errors++;
        $display("FAIL hazard_stall%0d: wr=%b inst_en=%b required 0/0", i, ctrl_rd_wr, inst_en);
      end
      step();
    end
    alu_empty = 1'b1;
    #1;
    checks++;
    if (ctrl_rd_wr !== 1'b1 || ctrl_rd_val !== 32'h4) begin
      errors++;
      $display("FAIL hazard_release: wr=%b val=%h required 1/00000004", ctrl_rd_wr, ctrl_rd_val);
    end
    step();
    checks++;
    if (inst_addr !== 16'h0800) begin
      errors++;
      $display("FAIL hazard_pc: addr=%h required 0800", inst_addr);
    end
  endtask

  task automatic test_illegal();
    apply_reset();
    fetch(32'h0020_A863);          // branch funct3=010
    checks++;
    if (dut.inst_error !== 1'b1) begin
      errors++;
      $display("FAIL illegal_branch: inst_error=%b required 1", dut.inst_error);
    end
    apply_reset();
    fetch(32'h0000_007F);
    checks++;
    if (dut.inst_error !== 1'b1 || alu_en !== 1'b0 || ctrl_rd_wr !== 1'b0) begin
      errors++;
      $display("FAIL illegal_flag: err/alu/wr=%b%b%b required 100", dut.inst_error, alu_en, ctrl_rd_wr);
    end
    step();
`ifdef FRISCV_ILLEGAL_HALT_EN
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (inst_en !== 1'b0 || alu_en !== 1'b0 || ctrl_rd_wr !== 1'b0) begin
        errors++;
        $display("FAIL illegal_halt%0d: en/alu/wr=%b%b%b required 000", i, inst_en, alu_en, ctrl_rd_wr);
      end
      step();
    end
    apply_reset();
    checks++;
    if (inst_en !== 1'b1 || inst_addr !== 16'h0) begin
      errors++;
      $display("FAIL halt_recover: inst_en=%b addr=%h required 1/0000", inst_en, inst_addr);
    end
`else
    checks++;
    if (inst_en !== 1'b1 || inst_addr !== 16'h0004 || dut.inst_error !== 1'b0) begin
      errors++;
      $display("FAIL illegal_skip: inst_en=%b addr=%h err=%b required 1/0004/0", inst_en, inst_addr, dut.inst_error);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_auipc();
    test_jal_jalr();
    test_branch();
    test_alu_stall();
    test_hazard();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
